pic_bram_arbiter: RTL and testbench
===================================

Name: pic_bram_arbiter

Overview:
- Shares the single read port of the picture BRAM (640x480, 12-bit RGB444) between two requesters: the VGA display scanout (port 0, high priority) and the sobel edge engine (port 1).
- Display has fixed priority. A starvation counter guarantees the sobel engine a grant after a bounded wait.
- A tag pipeline routes each returning read word to the requester that issued it, with a fixed and known latency.

Parameters:
- ADDR_W, 19, picture BRAM address width
- DATA_W, 12, pixel word width
- READ_LATENCY, 2, cycles from bram_addr register update to valid bram_dout; legal 1..4
- MAX_WAIT, 8, cycles port 1 may be denied while requesting before a forced grant; legal 1..255

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req0  in  1  display read request
- addr0  in  ADDR_W  display read address
- grant0  out  1  display request accepted this cycle
- rdata0  out  DATA_W  display read data
- rvalid0  out  1  rdata0 valid, one-cycle pulse
- req1  in  1  sobel read request
- addr1  in  ADDR_W  sobel read address
- grant1  out  1  sobel request accepted this cycle
- rdata1  out  DATA_W  sobel read data
- rvalid1  out  1  rdata1 valid, one-cycle pulse
- bram_addr  out  ADDR_W  picture BRAM read address
- bram_dout  in  DATA_W  picture BRAM read data
- busy  out  1  at least one read in flight

Behaviour:
- Reset: one clock, reset is asynchronous and active-low. While reset_n=0:
  - bram_addr, rdata0, rdata1 = 0
  - rvalid0, rvalid1, busy = 0
  - wait_cnt = 0, tag pipeline cleared
  - grant0 and grant1 forced 0
- Reset mid-operation: all in-flight reads are discarded, and no rvalid is produced for them after release.
- Request rules:
  - A requester holds req high and addr stable until it sees its grant.
  - A grant accepts exactly one read.
  - A requester may re-request in the cycle after its grant.
- Grants are combinational in the request cycle T. At most one grant per cycle.
- Arbitration, in order:
  - force1 = req1 & (wait_cnt == MAX_WAIT)
  - if force1: grant1=1
  - else if req0: grant0=1
  - else if req1: grant1=1
- Starvation counter (8-bit):
  - clears to 0 on grant1 or when req1=0
  - increments by 1 when req1=1 and grant1=0
  - saturates at MAX_WAIT
  - consequence: port 1 waits at most MAX_WAIT denied cycles
- Address path: on the clk edge ending cycle T with a grant, bram_addr <= granted addr. bram_addr holds its value when there is no grant.
- Tag pipeline:
  - depth L = READ_LATENCY+1
  - entry = {valid, port}, shifted every cycle
  - entry enters at the end of the grant cycle
- Return: when the tag exits (READ_LATENCY cycles after the bram_addr update):
  - the selected rdataN <= bram_dout and rvalidN <= 1 for one cycle
  - the other port's rdata is unchanged and its rvalid is 0
- Latency: grant in cycle T gives rvalid in cycle T+READ_LATENCY+1. This is fixed and independent of contention.
- Throughput: one read per cycle total, back-to-back grants allowed. Returns preserve issue order.
- busy = OR of the tag valid bits.
- Simultaneous requests:
  - req0 and req1 both high with wait_cnt < MAX_WAIT: grant0.
  - At MAX_WAIT: grant1, while port 0 keeps requesting and is granted next cycle.
- No requests: no grant, bram_addr unchanged, wait_cnt = 0.
- Address range is not checked. Addresses ≥ 307200 are passed through unchanged.

Test Plan:
- Single requester: req1 only, addr1=641, bram_dout model = addr[11:0] → grant1 in cycle 0, rvalid1 in cycle 3 with rdata1=12'h281, rvalid0 never asserted.
- Contention without starvation: req0 and req1 both held, MAX_WAIT=8 → grant0 for cycles 0–7, grant1 in cycle 8, grant0 in cycle 9. rvalid1 in cycle 11; every cycle 3–12 except 11 carries rvalid0.
- Back-to-back: port 0 addresses 0,1,2,3 on consecutive cycles with no port 1 traffic → rvalid0 high in cycles 3–6 with rdata0 = 0,1,2,3 in order, busy high in cycles 1–6.
- Interleaved routing: grants 0,1,0,1 with addresses 10,20,30,40 → returns alternate rvalid0/rvalid1 with data 10,20,30,40. The non-selected rdata holds its previous value.
- Reset mid-flight: assert reset_n=0 one cycle after two grants → all outputs 0 immediately. After release, no rvalid appears, busy=0, wait_cnt=0.
- READ_LATENCY=1 build: repeat the single-requester test → rvalid1 in cycle 2 with the correct data.

Source files
------------

// File: rtl/pic_bram_arbiter.sv
// Two-port read arbiter for the picture BRAM: display has fixed priority, and a
// starvation counter bounds the sobel wait. A tag pipeline routes returns back to their issuer.
module pic_bram_arbiter #(
   parameter int ADDR_W       = 19,
   parameter int DATA_W       = 12,
   parameter int READ_LATENCY = 2,
   parameter int MAX_WAIT     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              grant0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              grant1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              busy
);

   logic [7:0]              wait_cnt;
   logic                    force1;
   logic [READ_LATENCY-1:0] tag_valid;
   logic [READ_LATENCY-1:0] tag_port;
   logic                    ret_valid;
   logic                    ret_port;

   // Grants are gated by reset so nothing is accepted while the tag pipeline is held clear.
   always_comb begin
      force1 = req1 && (wait_cnt == 8'(MAX_WAIT));
      grant1 = reset_n && (force1 || (req1 && !req0));
      grant0 = reset_n && req0 && !force1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 8'd0;
      end else if (!req1 || grant1) begin
         wait_cnt <= 8'd0;
      end else if (wait_cnt != 8'(MAX_WAIT)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bram_addr <= '0;
      end else if (grant1) begin
         bram_addr <= addr1;
      end else if (grant0) begin
         bram_addr <= addr0;
      end
   end

   // Stage i holds the read issued i+1 cycles ago; the last stage lines up with valid bram_dout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_valid <= '0;
         tag_port  <= '0;
      end else begin
         tag_valid[0] <= grant0 || grant1;
         tag_port[0]  <= grant1;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_port[i]  <= tag_port[i-1];
         end
      end
   end

   assign ret_valid = tag_valid[READ_LATENCY-1];
   assign ret_port  = tag_port[READ_LATENCY-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata0  <= '0;
         rdata1  <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= ret_valid && !ret_port;
         rvalid1 <= ret_valid && ret_port;
         if (ret_valid && !ret_port) rdata0 <= bram_dout;
         if (ret_valid && ret_port)  rdata1 <= bram_dout;
      end
   end

   // The rvalid registers are the final tag stage, so they count as in flight.
   assign busy = (|tag_valid) || rvalid0 || rvalid1;

endmodule

// File: tb/tb_pic_bram_arbiter.sv
// Bench for pic_bram_arbiter: directed scenarios plus random traffic, checked
// against a queue-based model of grants, return timing and routed data.
module tb_pic_bram_arbiter;
   localparam int AW = 19;
   localparam int DW = 12;
   localparam int RL = 2;
   localparam int MW = 8;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // main instance, READ_LATENCY=2
   logic          req0, req1, grant0, grant1, rvalid0, rvalid1, busy;
   logic [AW-1:0] addr0, addr1, bram_addr;
   logic [DW-1:0] rdata0, rdata1, bram_dout;
   logic [AW-1:0] addr_hist;

   // second instance, READ_LATENCY=1
   logic          b_req0, b_req1, b_grant0, b_grant1, b_rvalid0, b_rvalid1, b_busy;
   logic [AW-1:0] b_addr0, b_addr1, b_bram_addr;
   logic [DW-1:0] b_rdata0, b_rdata1, b_dout;

   pic_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_WAIT(MW)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .addr0(addr0), .grant0(grant0), .rdata0(rdata0), .rvalid0(rvalid0),
      .req1(req1), .addr1(addr1), .grant1(grant1), .rdata1(rdata1), .rvalid1(rvalid1),
      .bram_addr(bram_addr), .bram_dout(bram_dout), .busy(busy));

   pic_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .MAX_WAIT(MW)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .req0(b_req0), .addr0(b_addr0), .grant0(b_grant0), .rdata0(b_rdata0), .rvalid0(b_rvalid0),
      .req1(b_req1), .addr1(b_addr1), .grant1(b_grant1), .rdata1(b_rdata1), .rvalid1(b_rvalid1),
      .bram_addr(b_bram_addr), .bram_dout(b_dout), .busy(b_busy));

   // BRAM content model: word = address[11:0]; latency 2 means one register after bram_addr
   always @(posedge clk) addr_hist <= bram_addr;
   assign bram_dout = addr_hist[11:0];
   assign b_dout    = b_bram_addr[11:0];

   typedef struct {
      bit        port;
      logic [11:0] data;
      int        due;
   } ret_t;

   ret_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          denied = 0;
   logic [AW-1:0] exp_bram = '0;
   logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
   logic        e0, e1;
   logic        obs_g1, obs_rv0, obs_rv1;
   logic [DW-1:0] obs_rd1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
      end
   endtask

   // One cycle of the main instance: compare at the falling edge, advance the model at the rising edge.
   task automatic tick();
      bit ev0, ev1;
      @(negedge clk);
      e1 = req1 && ((denied >= MW) || !req0);
      e0 = req0 && !e1;
      ev0 = 1'b0;
      ev1 = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         if (q[0].port) begin ev1 = 1'b1; exp_rd1 = q[0].data; end
         else           begin ev0 = 1'b1; exp_rd0 = q[0].data; end
      end
      chk("grant0", 32'(grant0), 32'(e0));
      chk("grant1", 32'(grant1), 32'(e1));
      chk("bram_addr", 32'(bram_addr), 32'(exp_bram));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("rvalid0", 32'(rvalid0), 32'(ev0));
      chk("rvalid1", 32'(rvalid1), 32'(ev1));
      chk("rdata0", 32'(rdata0), 32'(exp_rd0));
      chk("rdata1", 32'(rdata1), 32'(exp_rd1));
      obs_g1  = grant1;
      obs_rv0 = rvalid0;
      obs_rv1 = rvalid1;
      obs_rd1 = rdata1;
      @(posedge clk);
      if (ev0 || ev1) void'(q.pop_front());
      if (e0 || e1) begin
         q.push_back('{port: e1, data: (e1 ? addr1[11:0] : addr0[11:0]), due: cyc + RL + 1});
         exp_bram = e1 ? addr1 : addr0;
      end
      denied = (req1 && !e1) ? denied + 1 : 0;
      #1;
      cyc++;
   endtask

   bit p0, p1, got1;

   initial begin
      reset_n = 1'b0;
      req0 = 1'b1; addr0 = 19'd7;
      req1 = 1'b1; addr1 = 19'd9;
      b_req0 = 1'b0; b_addr0 = '0; b_req1 = 1'b0; b_addr1 = '0;
      #12;
      chk("rst_grant0", 32'(grant0), 0);
      chk("rst_grant1", 32'(grant1), 0);
      chk("rst_bram_addr", 32'(bram_addr), 0);
      chk("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
      chk("rst_rdata", 32'({rdata0, rdata1}), 0);
      chk("rst_busy", 32'(busy), 0);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick(); tick();

      // single requester on port 1
      for (int k = 0; k < 4; k++) begin
         req1 = (k == 0); addr1 = 19'd641;
         tick();
         chk("single_rv0", 32'(obs_rv0), 0);
         chk("single_rv1", 32'(obs_rv1), 32'(k == 3));
         if (k == 3) chk("single_rd1", 32'(obs_rd1), 32'h281);
      end
      req1 = 1'b0;
      repeat (3) tick();

      // contention: port 0 always requesting, port 1 forced through after MAX_WAIT denials
      got1 = 1'b0;
      for (int k = 0; k < 13; k++) begin
         req0 = 1'b1; addr0 = 19'(100 + k);
         req1 = !got1; addr1 = 19'd500;
         tick();
         chk("cont_grant1_cycle", 32'(obs_g1), 32'(k == 8));
         if (obs_g1) got1 = 1'b1;
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (5) tick();

      // back-to-back port 0
      for (int k = 0; k < 4; k++) begin
         req0 = 1'b1; addr0 = 19'(k);
         tick();
      end
      req0 = 1'b0;
      repeat (5) tick();

      // interleaved routing 0,1,0,1
      for (int k = 0; k < 4; k++) begin
         req0 = (k % 2 == 0); addr0 = 19'(10 + 20 * (k / 2));
         req1 = (k % 2 == 1); addr1 = 19'(20 + 20 * (k / 2));
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (5) tick();

      // reset mid-flight, one cycle after two grants
      req0 = 1'b1; addr0 = 19'd5; tick();
      req0 = 1'b0; req1 = 1'b1; addr1 = 19'd6; tick();
      req1 = 1'b0; tick();
      req0 = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_grant0", 32'(grant0), 0);
      chk("mid_rst_bram_addr", 32'(bram_addr), 0);
      chk("mid_rst_rvalid", 32'({rvalid0, rvalid1}), 0);
      chk("mid_rst_rdata", 32'({rdata0, rdata1}), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      req0 = 1'b0;
      q.delete();
      denied = 0; exp_bram = '0; exp_rd0 = '0; exp_rd1 = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      cyc++;
      repeat (5) tick();
      chk("mid_rst_wait_cnt", 32'(dut_a.wait_cnt), 0);

      // random traffic honouring the hold-until-granted rule
      p0 = 1'b0; p1 = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!p0 && $urandom_range(0, 3) != 0) begin p0 = 1'b1; addr0 = 19'($urandom_range(0, 524287)); end
         if (!p1 && $urandom_range(0, 1) != 0) begin p1 = 1'b1; addr1 = 19'($urandom_range(0, 524287)); end
         req0 = p0; req1 = p1;
         tick();
         if (e0) p0 = 1'b0;
         if (e1) p1 = 1'b0;
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (5) tick();

      // READ_LATENCY=1 instance, single requester on port 1
      b_req1 = 1'b1; b_addr1 = 19'd641;
      @(negedge clk);
      chk("b_grant1", 32'(b_grant1), 1);
      @(posedge clk); #1;
      b_req1 = 1'b0;
      @(negedge clk);
      chk("b_rvalid1_c1", 32'(b_rvalid1), 0);
      @(negedge clk);
      chk("b_rvalid1_c2", 32'(b_rvalid1), 1);
      chk("b_rdata1_c2", 32'(b_rdata1), 32'h281);
      chk("b_rvalid0_c2", 32'(b_rvalid0), 0);
      @(negedge clk);
      chk("b_rvalid1_c3", 32'(b_rvalid1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
